// File: rtl/fetch_queue.sv
// Fetch-side instruction buffer between the PC register and Decode.
// Tags address errors on entry and drops all contents on flush.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_bd,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 out_exc,
  output logic                       out_bd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   push_c, pop_c, addr_err_c;
  entry_t wr_entry_c, head_c;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push_c = in_valid & in_ready & ~flush;
  assign pop_c  = out_valid & out_ready & ~flush;

  // Misaligned or out-of-window fetches become AdEL with a zeroed instruction.
  assign addr_err_c = (in_pc[1:0] != 2'b00) || (in_pc < PC_LO) || (in_pc > PC_HI);

  always_comb begin
    wr_entry_c.pc    = in_pc;
    wr_entry_c.bd    = in_bd;
    wr_entry_c.instr = in_instr;
    wr_entry_c.exc   = 5'd0;
    if (addr_err_c) begin
      wr_entry_c.instr = 32'd0;
      wr_entry_c.exc   = EXC_ADEL;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot payload needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

  assign head_c = mem_q[rd_ptr_q];

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = 32'd0;
    out_exc   = 5'd0;
    out_bd    = 1'b0;
    if (out_valid) begin
      out_pc    = head_c.pc;
      out_instr = head_c.instr;
      out_exc   = head_c.exc;
      out_bd    = head_c.bd;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences for flush and
// async reset, then random traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_bd, flush, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid, out_bd;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_exc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_bd(out_bd),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;

  ent_t model_q[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic        ordy;
    logic        fl;
    int unsigned e_cnt;
    logic        e_val;
    logic        e_rdy;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [4:0]  e_exc;
    logic        e_bd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] instr, logic bd,
                              logic ordy, logic fl, int unsigned e_cnt, logic e_val,
                              logic e_rdy, logic [31:0] e_pc, logic [31:0] e_instr,
                              logic [4:0] e_exc, logic e_bd);
    vec_t r;
    r.v = v; r.pc = pc; r.instr = instr; r.bd = bd; r.ordy = ordy; r.fl = fl;
    r.e_cnt = e_cnt; r.e_val = e_val; r.e_rdy = e_rdy; r.e_pc = e_pc;
    r.e_instr = e_instr; r.e_exc = e_exc; r.e_bd = e_bd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model at the edge, sample 1 unit later.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic bd, input logic ordy, input logic fl);
    bit   do_push, do_pop;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_instr = instr; in_bd = bd;
    out_ready = ordy; flush = fl;
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() != 0) && ordy && !fl;
    e.pc  = pc;
    e.bd  = bd;
    if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFF) begin
      e.exc = 5'd4; e.instr = 32'd0;
    end else begin
      e.exc = 5'd0; e.instr = instr;
    end
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic cmp_model(input string tag);
    bit          nz;
    logic [31:0] e_pc, e_instr;
    logic [4:0]  e_exc;
    logic        e_bd;
    nz = (model_q.size() != 0);
    e_pc = 32'h3000; e_instr = 32'd0; e_exc = 5'd0; e_bd = 1'b0;
    if (nz) begin
      e_pc = model_q[0].pc; e_instr = model_q[0].instr;
      e_exc = model_q[0].exc; e_bd = model_q[0].bd;
    end
    chk({tag, " count"},     32'(count),     32'(model_q.size()));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(nz));
    chk({tag, " in_ready"},  32'(in_ready),  32'(model_q.size() < DEPTH));
    chk({tag, " out_pc"},    out_pc,         e_pc);
    chk({tag, " out_instr"}, out_instr,      e_instr);
    chk({tag, " out_exc"},   32'(out_exc),   32'(e_exc));
    chk({tag, " out_bd"},    32'(out_bd),    32'(e_bd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_pc = 32'd0; in_instr = 32'd0; in_bd = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    // Fill, overfill, drain.
    tbl.push_back(mk(1, 32'h3000, 32'h3C010001, 0, 0, 0, 1, 1, 1, 32'h3000, 32'h3C010001, 0, 0));
    tbl.push_back(mk(1, 32'h3004, 32'h34210002, 0, 0, 0, 2, 1, 1, 32'h3000, 32'h3C010001, 0, 0));
    tbl.push_back(mk(1, 32'h3008, 32'h24420003, 0, 0, 0, 3, 1, 1, 32'h3000, 32'h3C010001, 0, 0));
    tbl.push_back(mk(1, 32'h300C, 32'h00431020, 0, 0, 0, 4, 1, 0, 32'h3000, 32'h3C010001, 0, 0));
    tbl.push_back(mk(1, 32'h3010, 32'h11111111, 0, 0, 0, 4, 1, 0, 32'h3000, 32'h3C010001, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 3, 1, 1, 32'h3004, 32'h34210002, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 2, 1, 1, 32'h3008, 32'h24420003, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 1, 1, 1, 32'h300C, 32'h00431020, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 0, 0, 1, 32'h3000, 32'h0,        0, 0));
    // Address exceptions and the legal upper boundary.
    tbl.push_back(mk(1, 32'h3002, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 1, 32'h3002, 32'h0,        4, 0));
    tbl.push_back(mk(1, 32'h7000, 32'hFFFFFFFF, 0, 1, 0, 1, 1, 1, 32'h7000, 32'h0,        4, 0));
    tbl.push_back(mk(1, 32'h2FFC, 32'hFFFFFFFF, 0, 1, 0, 1, 1, 1, 32'h2FFC, 32'h0,        4, 0));
    tbl.push_back(mk(1, 32'h6FFC, 32'hFFFFFFFF, 0, 1, 0, 1, 1, 1, 32'h6FFC, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 0, 0, 1, 32'h3000, 32'h0,        0, 0));
    // Full with simultaneous pop: push refused, pop taken.
    tbl.push_back(mk(1, 32'h5000, 32'h5000, 0, 0, 0, 1, 1, 1, 32'h5000, 32'h5000, 0, 0));
    tbl.push_back(mk(1, 32'h5004, 32'h5004, 0, 0, 0, 2, 1, 1, 32'h5000, 32'h5000, 0, 0));
    tbl.push_back(mk(1, 32'h5008, 32'h5008, 0, 0, 0, 3, 1, 1, 32'h5000, 32'h5000, 0, 0));
    tbl.push_back(mk(1, 32'h500C, 32'h500C, 0, 0, 0, 4, 1, 0, 32'h5000, 32'h5000, 0, 0));
    tbl.push_back(mk(1, 32'h5010, 32'h5010, 0, 1, 0, 3, 1, 1, 32'h5004, 32'h5004, 0, 0));
    tbl.push_back(mk(0, 32'h0,    32'h0,    0, 1, 0, 2, 1, 1, 32'h5008, 32'h5008, 0, 0));
    // Steady push+pop at count 2 across pointer wrap.
    tbl.push_back(mk(1, 32'h5010, 32'h5010, 0, 1, 0, 2, 1, 1, 32'h500C, 32'h500C, 0, 0));
    tbl.push_back(mk(1, 32'h5014, 32'h5014, 0, 1, 0, 2, 1, 1, 32'h5010, 32'h5010, 0, 0));
    tbl.push_back(mk(1, 32'h5018, 32'h5018, 0, 1, 0, 2, 1, 1, 32'h5014, 32'h5014, 0, 0));
    tbl.push_back(mk(1, 32'h501C, 32'h501C, 0, 1, 0, 2, 1, 1, 32'h5018, 32'h5018, 0, 0));
    tbl.push_back(mk(1, 32'h5020, 32'h5020, 0, 1, 0, 2, 1, 1, 32'h501C, 32'h501C, 0, 0));
    tbl.push_back(mk(1, 32'h5024, 32'h5024, 0, 1, 0, 2, 1, 1, 32'h5020, 32'h5020, 0, 0));
    // Flush with a concurrent push, then recovery.
    tbl.push_back(mk(1, 32'h5028, 32'h5028, 0, 0, 0, 3, 1, 1, 32'h5020, 32'h5020, 0, 0));
    tbl.push_back(mk(1, 32'h4000, 32'h4000, 0, 1, 1, 0, 0, 1, 32'h3000, 32'h0,     0, 0));
    tbl.push_back(mk(1, 32'h4180, 32'h12345678, 1, 0, 0, 1, 1, 1, 32'h4180, 32'h12345678, 0, 1));
    tbl.push_back(mk(0, 32'h0,    32'h0,        0, 0, 0, 1, 1, 1, 32'h4180, 32'h12345678, 0, 1));

    // Reset values while held in reset.
    #12;
    chk("reset count",     32'(count),     32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_pc",    out_pc,         32'h3000);
    chk("reset out_instr", out_instr,      32'd0);
    chk("reset out_exc",   32'(out_exc),   32'd0);
    chk("reset out_bd",    32'(out_bd),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].bd, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d count", i),     32'(count),     32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
      chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d out_pc", i),    out_pc,         tbl[i].e_pc);
      chk($sformatf("vec%0d out_instr", i), out_instr,      tbl[i].e_instr);
      chk($sformatf("vec%0d out_exc", i),   32'(out_exc),   32'(tbl[i].e_exc));
      chk($sformatf("vec%0d out_bd", i),    32'(out_bd),    32'(tbl[i].e_bd));
    end

    // Async reset between edges with three entries held.
    cycle(1, 32'h3100, 32'hA, 0, 0, 0);
    cycle(1, 32'h3104, 32'hB, 0, 0, 0);
    chk("pre-areset count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset count",     32'(count),     32'd0);
    chk("areset out_valid", 32'(out_valid), 32'd0);
    chk("areset in_ready",  32'(in_ready),  32'd1);
    chk("areset out_pc",    out_pc,         32'h3000);
    model_q.delete();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_model("post-areset");

    // Random traffic against the reference queue.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      case ($urandom_range(0, 5))
        0:       rpc = 32'h3000 + 32'($urandom_range(0, 4095));
        1:       rpc = 32'h2F00 + 32'($urandom_range(0, 511));
        2:       rpc = 32'h6F00 + 32'($urandom_range(0, 511));
        default: rpc = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), rpc, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
